// File: rtl/aibcr3aux_rst_seq_if.sv
// Aux reset sequencer signal bundle.
// The sequencer sits on the slave side. The bench or the aux top wrapper sits on the master side.
interface aibcr3aux_rst_seq_if;
    logic       i_por_vccl;
    logic       i_por_vcchssi;
    logic       i_por_vccl_ovrd;
    logic       i_dn_por;
    logic       i_dn_rst_n;
    logic       i_dll_lock;
    logic       o_io_rst_n;
    logic       o_dll_rst_n;
    logic       o_adapter_rst_n;
    logic       o_por_done;
    logic       o_lock_err;
    logic [2:0] o_state;

    modport master (
        output i_por_vccl, i_por_vcchssi, i_por_vccl_ovrd, i_dn_por, i_dn_rst_n, i_dll_lock,
        input  o_io_rst_n, o_dll_rst_n, o_adapter_rst_n, o_por_done, o_lock_err, o_state
    );

    modport slave (
        input  i_por_vccl, i_por_vcchssi, i_por_vccl_ovrd, i_dn_por, i_dn_rst_n, i_dll_lock,
        output o_io_rst_n, o_dll_rst_n, o_adapter_rst_n, o_por_done, o_lock_err, o_state
    );
endinterface

// File: rtl/aibcr3aux_rst_seq.sv
// Aux-channel reset sequencer: debounces power-good and releases IO, DLL and adapter resets in order.
// DLL release waits for lock, and a timeout leads to an error state.
module aibcr3aux_rst_seq #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned CNT_W        = 10,
    parameter int unsigned DEB_CYCLES   = 64,
    parameter int unsigned STAGE_GAP    = 16,
    parameter int unsigned LOCK_TIMEOUT = 256
) (
    input  logic                i_osc_clk,
    input  logic                i_rst,
    aibcr3aux_rst_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_RESET    = 3'd0,
        ST_WAIT_PWR = 3'd1,
        ST_DEBOUNCE = 3'd2,
        ST_REL_IO   = 3'd3,
        ST_REL_DLL  = 3'd4,
        ST_DONE     = 3'd5,
        ST_ERR      = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);

    // Bit order: {lock, ovrd, dn_rst_n, dn_por, por_vcchssi, por_vccl}. The reset value reports every domain in POR.
    localparam logic [5:0] SYNC_RST = 6'b000111;

    logic [5:0]       w_async_in;
    logic [5:0]       r_sync [SYNC_STAGES];
    logic [5:0]       w_sync;
    logic             w_por_vccl_s;
    logic             w_por_vcchssi_s;
    logic             w_dn_por_s;
    logic             w_dn_rst_n_s;
    logic             w_ovrd_s;
    logic             w_lock_s;
    logic             w_pwr_ok;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_io_rst_n;
    logic             r_dll_rst_n;
    logic             r_adapter_rst_n;
    logic             r_por_done;
    logic             r_lock_err;

    assign w_async_in = {bus.i_dll_lock, bus.i_por_vccl_ovrd, bus.i_dn_rst_n,
                         bus.i_dn_por, bus.i_por_vcchssi, bus.i_por_vccl};

    always_ff @(posedge i_osc_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= SYNC_RST;
            end
        end else begin
            r_sync[0] <= w_async_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_sync          = r_sync[SYNC_STAGES-1];
    assign w_por_vccl_s    = w_sync[0];
    assign w_por_vcchssi_s = w_sync[1];
    assign w_dn_por_s      = w_sync[2];
    assign w_dn_rst_n_s    = w_sync[3];
    assign w_ovrd_s        = w_sync[4];
    assign w_lock_s        = w_sync[5];

    assign w_pwr_ok = ~(w_por_vccl_s & ~w_ovrd_s) & ~w_por_vcchssi_s & ~w_dn_por_s & w_dn_rst_n_s;

    // Power loss is checked first in every state. This gives it priority over the debounce, gap and lock transitions.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_RESET: begin
                w_state_nxt = ST_WAIT_PWR;
                w_cnt_nxt   = '0;
            end
            ST_WAIT_PWR: begin
                if (w_pwr_ok) begin
                    w_state_nxt = ST_DEBOUNCE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_DEBOUNCE: begin
                if (!w_pwr_ok) begin
                    w_state_nxt = ST_WAIT_PWR;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt = ST_REL_IO;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_REL_IO: begin
                if (!w_pwr_ok) begin
                    w_state_nxt = ST_WAIT_PWR;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == GAP_LAST) begin
                    w_state_nxt = ST_REL_DLL;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_REL_DLL: begin
                if (!w_pwr_ok) begin
                    w_state_nxt = ST_WAIT_PWR;
                    w_cnt_nxt   = '0;
                end else if (w_lock_s) begin
                    w_state_nxt = ST_DONE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TO_LAST) begin
                    w_state_nxt = ST_ERR;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE, ST_ERR: begin
                if (!w_pwr_ok) begin
                    w_state_nxt = ST_WAIT_PWR;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_RESET;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state. This keeps them registered and in step with r_state.
    always_ff @(posedge i_osc_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= ST_RESET;
            r_cnt           <= '0;
            r_io_rst_n      <= 1'b0;
            r_dll_rst_n     <= 1'b0;
            r_adapter_rst_n <= 1'b0;
            r_por_done      <= 1'b0;
            r_lock_err      <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_io_rst_n      <= (w_state_nxt inside {ST_REL_IO, ST_REL_DLL, ST_DONE, ST_ERR});
            r_dll_rst_n     <= (w_state_nxt inside {ST_REL_DLL, ST_DONE});
            r_adapter_rst_n <= (w_state_nxt == ST_DONE);
            r_por_done      <= (w_state_nxt == ST_DONE);
            r_lock_err      <= (w_state_nxt == ST_ERR);
        end
    end

    assign bus.o_state         = r_state;
    assign bus.o_io_rst_n      = r_io_rst_n;
    assign bus.o_dll_rst_n     = r_dll_rst_n;
    assign bus.o_adapter_rst_n = r_adapter_rst_n;
    assign bus.o_por_done      = r_por_done;
    assign bus.o_lock_err      = r_lock_err;

endmodule

// File: tb/tb_aibcr3aux_rst_seq.sv
// Bench for aibcr3aux_rst_seq: directed vector table, hand-written corner sequences, and random stimulus.
// Every negedge compares the DUT against a run-length reference model.
module tb_aibcr3aux_rst_seq;

    localparam int SYNC = 2;
    localparam int DEB  = 64;
    localparam int GAP  = 16;
    localparam int LT   = 256;

    // Input bit order: {ovrd, lock, dn_rst_n, dn_por, por_vcchssi, por_vccl}
    localparam logic [5:0] BAD  = 6'b000111;
    localparam logic [5:0] GOOD = 6'b001000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    aibcr3aux_rst_seq_if bus_if ();

    aibcr3aux_rst_seq #(
        .SYNC_STAGES (SYNC),
        .CNT_W       (10),
        .DEB_CYCLES  (DEB),
        .STAGE_GAP   (GAP),
        .LOCK_TIMEOUT(LT)
    ) dut (
        .i_osc_clk (clk),
        .i_rst     (rst),
        .bus       (bus_if)
    );

    // Reference model. Each synchronized input is the raw input SYNC edges earlier.
    // State follows from the run length of power-good edges and the lock decision made inside the REL_DLL window.
    bit m_q_pwr[$];
    bit m_q_lock[$];
    int m_gr;
    int m_outcome;     // 0 undecided, 1 locked, 2 timed out
    bit m_rst_state;
    bit m_p, m_l;
    int m_k;

    function automatic bit raw_pwr_ok();
        return !(bus_if.i_por_vccl && !bus_if.i_por_vccl_ovrd) && !bus_if.i_por_vcchssi &&
               !bus_if.i_dn_por && bus_if.i_dn_rst_n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q_pwr.delete();
            m_q_lock.delete();
            for (int i = 0; i < SYNC; i++) begin
                m_q_pwr.push_back(1'b0);
                m_q_lock.push_back(1'b0);
            end
            m_gr        = 0;
            m_outcome   = 0;
            m_rst_state = 1'b1;
        end else begin
            m_p = m_q_pwr.pop_front();
            m_l = m_q_lock.pop_front();
            m_q_pwr.push_back(raw_pwr_ok());
            m_q_lock.push_back(bus_if.i_dll_lock);
            if (m_rst_state) begin
                m_rst_state = 1'b0;
            end else if (!m_p) begin
                m_gr      = 0;
                m_outcome = 0;
            end else begin
                m_gr = m_gr + 1;
                m_k  = m_gr - (DEB + GAP + 1);
                if (m_outcome == 0 && m_k >= 1 && m_k <= LT) begin
                    if (m_l) m_outcome = 1;
                    else if (m_k == LT) m_outcome = 2;
                end
            end
        end
    end

    function automatic logic [7:0] model_exp();
        int s;
        if (m_rst_state)                s = 0;
        else if (m_gr == 0)             s = 1;
        else if (m_gr <= DEB)           s = 2;
        else if (m_gr <= DEB + GAP)     s = 3;
        else if (m_outcome == 1)        s = 5;
        else if (m_outcome == 2)        s = 6;
        else                            s = 4;
        return {3'(s), (s >= 3), (s == 4 || s == 5), (s == 5), (s == 5), (s == 6)};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {bus_if.o_state, bus_if.o_io_rst_n, bus_if.o_dll_rst_n,
                bus_if.o_adapter_rst_n, bus_if.o_por_done, bus_if.o_lock_err};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got state/outs %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) chk("model", dut_vec(), model_exp());
    end

    task automatic drive(input logic [5:0] v);
        bus_if.i_por_vccl      = v[0];
        bus_if.i_por_vcchssi   = v[1];
        bus_if.i_dn_por        = v[2];
        bus_if.i_dn_rst_n      = v[3];
        bus_if.i_dll_lock      = v[4];
        bus_if.i_por_vccl_ovrd = v[5];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(BAD);
        rst = 1'b1;
        tick();
        tick();
        chk("reset_state", dut_vec(), 8'h00);
        rst = 1'b0;
        tick();
        chk("reset_exit", dut_vec(), {3'd1, 5'b00000});
    endtask

    typedef struct {
        logic [5:0] in;
        int         n;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[18];
    logic [5:0] cur;
    bit any_io;
    int lockpct;
    int len;

    initial begin
        vecs[0]  = '{in: BAD,       n: 10,  exp: {3'd1, 5'b00000}, name: "wait_pwr"};
        vecs[1]  = '{in: GOOD,      n: 66,  exp: {3'd2, 5'b00000}, name: "debounce_last"};
        vecs[2]  = '{in: GOOD,      n: 1,   exp: {3'd3, 5'b10000}, name: "io_release_67"};
        vecs[3]  = '{in: GOOD,      n: 15,  exp: {3'd3, 5'b10000}, name: "gap_hold"};
        vecs[4]  = '{in: GOOD,      n: 1,   exp: {3'd4, 5'b11000}, name: "dll_release_16"};
        vecs[5]  = '{in: GOOD,      n: 20,  exp: {3'd4, 5'b11000}, name: "rel_dll_wait"};
        vecs[6]  = '{in: 6'b011000, n: 2,   exp: {3'd4, 5'b11000}, name: "lock_sync"};
        vecs[7]  = '{in: 6'b011000, n: 1,   exp: {3'd5, 5'b11110}, name: "done_3_after_lock"};
        vecs[8]  = '{in: GOOD,      n: 10,  exp: {3'd5, 5'b11110}, name: "done_ignores_lock_loss"};
        vecs[9]  = '{in: 6'b001010, n: 2,   exp: {3'd5, 5'b11110}, name: "pwr_loss_sync"};
        vecs[10] = '{in: 6'b001010, n: 1,   exp: {3'd1, 5'b00000}, name: "pwr_loss_done"};
        vecs[11] = '{in: 6'b001001, n: 200, exp: {3'd1, 5'b00000}, name: "vccl_no_ovrd"};
        vecs[12] = '{in: 6'b101001, n: 67,  exp: {3'd3, 5'b10000}, name: "ovrd_io"};
        vecs[13] = '{in: 6'b101001, n: 16,  exp: {3'd4, 5'b11000}, name: "ovrd_dll"};
        vecs[14] = '{in: 6'b101001, n: 255, exp: {3'd4, 5'b11000}, name: "timeout_minus1"};
        vecs[15] = '{in: 6'b101001, n: 1,   exp: {3'd6, 5'b10001}, name: "timeout_err"};
        vecs[16] = '{in: 6'b111001, n: 10,  exp: {3'd6, 5'b10001}, name: "err_holds"};
        vecs[17] = '{in: 6'b110001, n: 3,   exp: {3'd1, 5'b00000}, name: "err_pwr_loss"};

        drive(BAD);
        tick();
        chk_en = 1'b1;
        do_reset();

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].in);
            repeat (vecs[i].n) tick();
            chk(vecs[i].name, dut_vec(), vecs[i].exp);
        end

        // Debounce glitch: dn_por pulses for 3 cycles at count 40
        do_reset();
        repeat (4) tick();
        drive(GOOD);
        repeat (43) tick();
        chk("glitch_pre", dut_vec(), {3'd2, 5'b00000});
        drive(6'b001100);
        repeat (3) tick();
        chk("glitch_wait", dut_vec(), {3'd1, 5'b00000});
        drive(GOOD);
        any_io = 1'b0;
        for (int i = 0; i < 66; i++) begin
            tick();
            any_io = any_io | bus_if.o_io_rst_n;
        end
        chk("glitch_io_held", {7'd0, any_io}, 8'd0);
        tick();
        chk("glitch_full_restart", dut_vec(), {3'd3, 5'b10000});

        // Lock arriving in the last REL_DLL cycle wins over the timeout
        do_reset();
        repeat (4) tick();
        drive(GOOD);
        repeat (83) tick();
        chk("last_lock_entry", dut_vec(), {3'd4, 5'b11000});
        repeat (253) tick();
        drive(6'b011000);
        repeat (2) tick();
        chk("last_lock_pre", dut_vec(), {3'd4, 5'b11000});
        tick();
        chk("last_lock_done", dut_vec(), {3'd5, 5'b11110});

        // Asynchronous reset between edges while in REL_DLL
        do_reset();
        repeat (4) tick();
        drive(GOOD);
        repeat (90) tick();
        chk("arst_pre", dut_vec(), {3'd4, 5'b11000});
        #2 rst = 1'b1;
        #1 chk("arst_immediate", dut_vec(), 8'h00);
        #3 rst = 1'b0;
        tick();
        chk("arst_wait", dut_vec(), {3'd1, 5'b00000});
        tick();
        chk("arst_sync_hold", dut_vec(), {3'd1, 5'b00000});
        tick();
        chk("arst_debounce", dut_vec(), {3'd2, 5'b00000});

        // Random episodes checked by the model at every negedge
        for (int ep = 0; ep < 30; ep++) begin
            if ($urandom_range(0, 3) == 0) do_reset();
            case ($urandom_range(0, 3))
                0: lockpct = 0;
                1: lockpct = 2;
                2: lockpct = 30;
                default: lockpct = 100;
            endcase
            cur    = GOOD;
            cur[5] = 1'($urandom_range(0, 1));
            len    = int'($urandom_range(100, 700));
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 99) < 3) cur[3:0] = 4'($urandom_range(0, 15));
                else if ($urandom_range(0, 99) < 5) cur[3:0] = 4'b1000;
                cur[4] = ($urandom_range(0, 99) < lockpct);
                drive(cur);
                tick();
                if ($urandom_range(0, 1499) == 0) begin
                    #2 rst = 1'b1;
                    #4 rst = 1'b0;
                end
            end
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
